// File: rtl/mfcc_mel_filter_acc.sv
// mfcc_mel_filter_acc
//   One mel filter channel of the MFCC front end. Streams the FFT power
//   spectrum, weights each bin with this channel's triangular filter
//   coefficient from its own ROM and accumulates one energy per frame.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   pwr_data     unsigned bin power
//   pwr_valid    pwr_data valid this cycle (no backpressure, gaps allowed)
//   pwr_last     last bin of the frame (qualified by pwr_valid)
//   rom_addr     weight ROM address, equals index of the bin being presented
//   rom_rd_data  weight returned by the ROM
//   mel_energy   accumulated energy of the last finished frame (held)
//   mel_valid    one-cycle pulse: mel_energy is new
//   mel_sat      accumulator saturated in the reported frame (with mel_valid)
//   bin_ovf      sticky: bin counter wrapped without pwr_last
module mfcc_mel_filter_acc #(
    parameter int unsigned PWR_WIDTH  = 32,
    parameter int unsigned W_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned ROM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PWR_WIDTH-1:0]  pwr_data,
    input  logic                  pwr_valid,
    input  logic                  pwr_last,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [W_WIDTH-1:0]    rom_rd_data,
    output logic [ACC_WIDTH-1:0]  mel_energy,
    output logic                  mel_valid,
    output logic                  mel_sat,
    output logic                  bin_ovf
);

    localparam int unsigned PROD_WIDTH = PWR_WIDTH + W_WIDTH;

    logic [ADDR_WIDTH-1:0] bin_cnt_q;
    logic                  bin_ovf_q;

    logic                  s1_valid_q;
    logic                  s1_last_q;
    logic [PWR_WIDTH-1:0]  s1_pwr_q;
    logic [W_WIDTH-1:0]    s1_w_q;

    logic                  s2_valid_q;
    logic                  s2_last_q;
    logic [ACC_WIDTH-1:0]  s2_prod_q;

    logic [ACC_WIDTH-1:0]  acc_q;
    logic                  sat_q;
    logic [ACC_WIDTH-1:0]  mel_energy_q;
    logic                  mel_valid_q;
    logic                  mel_sat_q;

    logic [W_WIDTH-1:0]    w_sel;
    logic [PROD_WIDTH-1:0] prod_full;
    logic [PROD_WIDTH-1:0] prod_shr;
    logic [ACC_WIDTH-1:0]  prod_d;
    logic [ACC_WIDTH:0]    sum;
    logic                  add_ovf;
    logic [ACC_WIDTH-1:0]  add_result;

    assign rom_addr   = bin_cnt_q;
    assign bin_ovf    = bin_ovf_q;
    assign mel_energy = mel_energy_q;
    assign mel_valid  = mel_valid_q;
    assign mel_sat    = mel_sat_q;

    // Bin counter doubles as the ROM address of the bin on the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt_q <= '0;
            bin_ovf_q <= 1'b0;
        end else if (pwr_valid) begin
            if (pwr_last) begin
                bin_cnt_q <= '0;
            end else if (bin_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                bin_cnt_q <= '0;
                bin_ovf_q <= 1'b1;
            end else begin
                bin_cnt_q <= bin_cnt_q + 1'b1;
            end
        end
    end

    // S1: align the power sample with the weight. A registered ROM delivers
    // its data in the same cycle S1 holds the matching sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_pwr_q   <= '0;
            s1_w_q     <= '0;
        end else begin
            s1_valid_q <= pwr_valid;
            s1_last_q  <= pwr_valid & pwr_last;
            s1_pwr_q   <= pwr_data;
            s1_w_q     <= rom_rd_data;
        end
    end

    always_comb begin
        w_sel      = (ROM_LAT == 0) ? s1_w_q : rom_rd_data;
        prod_full  = PROD_WIDTH'(s1_pwr_q) * PROD_WIDTH'(w_sel);
        prod_shr   = prod_full >> SHIFT;
        prod_d     = ACC_WIDTH'(prod_shr);
        sum        = {1'b0, acc_q} + {1'b0, s2_prod_q};
        add_ovf    = sum[ACC_WIDTH];
        add_result = add_ovf ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    end

    // S2: scaled product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_prod_q  <= prod_d;
        end
    end

    // S3: saturating accumulate. The last item bypasses the accumulator into
    // mel_energy and clears it, so the next frame's first add starts from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            sat_q        <= 1'b0;
            mel_energy_q <= '0;
            mel_valid_q  <= 1'b0;
            mel_sat_q    <= 1'b0;
        end else begin
            mel_valid_q <= 1'b0;
            if (s2_valid_q) begin
                if (s2_last_q) begin
                    mel_energy_q <= add_result;
                    mel_valid_q  <= 1'b1;
                    mel_sat_q    <= sat_q | add_ovf;
                    acc_q        <= '0;
                    sat_q        <= 1'b0;
                end else begin
                    acc_q <= add_result;
                    sat_q <= sat_q | add_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_mfcc_mel_filter_acc.sv
// tb_mfcc_mel_filter_acc
//   Drives directed and randomized frames into the mel filter accumulator
//   with a registered ROM model (weight = addr[7:0]) and compares results
//   against a frame-level arithmetic reference model.
module tb_mfcc_mel_filter_acc;

    logic        clk_tb;
    logic        tb_rst;
    logic [31:0] pwr_data;
    logic        pwr_valid;
    logic        pwr_last;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_rd_data;
    logic [31:0] mel_energy;
    logic        mel_valid;
    logic        mel_sat;
    logic        bin_ovf;

    mfcc_mel_filter_acc dut (
        .clk         (clk_tb),
        .rst         (tb_rst),
        .pwr_data    (pwr_data),
        .pwr_valid   (pwr_valid),
        .pwr_last    (pwr_last),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .mel_energy  (mel_energy),
        .mel_valid   (mel_valid),
        .mel_sat     (mel_sat),
        .bin_ovf     (bin_ovf)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    // Registered-read weight ROM.
    always @(posedge clk_tb) rom_rd_data <= rom_addr[7:0];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        longint e;
        bit     s;
        int     due;
    } exp_t;

    exp_t   exp_q[$];
    int     model_idx  = 0;
    bit     model_ovf  = 0;
    longint model_acc  = 0;
    bit     model_sat  = 0;
    longint exp_hold   = 0;
    int     neg_cnt    = 0;

    task automatic model_reset();
        model_idx = 0;
        model_ovf = 0;
        model_acc = 0;
        model_sat = 0;
        exp_hold  = 0;
        exp_q.delete();
    endtask

    // One clock of stimulus; called 1 time unit after a rising edge.
    task automatic step(input bit v, input logic [31:0] p, input bit l);
        longint prod;
        longint s;
        exp_t   it;
        check("rom_addr", 64'(rom_addr), 64'(model_idx));
        check("bin_ovf", 64'(bin_ovf), 64'(model_ovf));
        pwr_valid = v;
        pwr_data  = p;
        pwr_last  = l;
        @(posedge clk_tb);
        if (v) begin
            prod = ((longint'(p) * longint'(model_idx % 256)) >> 8) & 64'hFFFF_FFFF;
            s = model_acc + prod;
            if (s > 64'hFFFF_FFFF) begin
                s = 64'hFFFF_FFFF;
                model_sat = 1;
            end
            if (l) begin
                it.e = s;
                it.s = model_sat;
                it.due = neg_cnt + 3;
                exp_q.push_back(it);
                model_acc = 0;
                model_sat = 0;
                model_idx = 0;
            end else begin
                model_acc = s;
                if (model_idx == 511) begin
                    model_idx = 0;
                    model_ovf = 1;
                end else begin
                    model_idx++;
                end
            end
        end
        #1;
    endtask

    task automatic frame(input int n, input logic [31:0] p, input bit gaps);
        for (int i = 0; i < n; i++) begin
            step(1'b1, p, i == n - 1);
            if (gaps) step(1'b0, 32'hDEAD_BEEF, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
    endtask

    // Output monitor: sampled on the falling edge.
    always @(negedge clk_tb) begin
        exp_t it;
        neg_cnt++;
        if (mel_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_mel_valid", 64'(mel_valid), 64'd0);
            end else begin
                it = exp_q.pop_front();
                check("latency", 64'(neg_cnt), 64'(it.due));
                check("mel_energy", 64'(mel_energy), 64'(it.e));
                check("mel_sat", 64'(mel_sat), 64'(it.s));
                exp_hold = it.e;
            end
        end else begin
            check("energy_hold", 64'(mel_energy), 64'(exp_hold));
            if (exp_q.size() > 0 && exp_q[0].due < neg_cnt) begin
                check("missed_mel_valid", 64'd0, 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int len;
        bit big;
        tb_rst    = 1'b1;
        pwr_valid = 1'b0;
        pwr_data  = '0;
        pwr_last  = 1'b0;
        repeat (3) @(posedge clk_tb);
        #1;
        check("rst_mel_valid", 64'(mel_valid), 64'd0);
        check("rst_mel_energy", 64'(mel_energy), 64'd0);
        check("rst_mel_sat", 64'(mel_sat), 64'd0);
        check("rst_bin_ovf", 64'(bin_ovf), 64'd0);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        tb_rst = 1'b0;
        idle(2);

        // Full ramp frame: 2 * (0+..+255) = 65280.
        frame(512, 32'd256, 1'b0);
        idle(4);
        // Same frame with a bubble after every bin.
        frame(512, 32'd256, 1'b1);
        idle(4);
        // Saturating frame, then a clean frame must report no saturation.
        frame(512, 32'hFFFF_FFFF, 1'b0);
        frame(512, 32'd256, 1'b0);
        idle(4);
        // Back-to-back short frames: 6 then 12.
        frame(4, 32'd256, 1'b0);
        frame(4, 32'd512, 1'b0);
        idle(4);
        // Single-bin frame at index 0 with a nonzero weight index afterward.
        frame(1, 32'hFFFF_FFFF, 1'b0);
        frame(2, 32'hFFFF_FFFF, 1'b0);
        idle(4);

        // Randomized frames with gaps and stray pwr_last without pwr_valid.
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, 300);
            big = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0) step(1'b0, $urandom, $urandom_range(0, 1) == 1);
                step(1'b1, big ? $urandom : 32'($urandom_range(0, 5000)), i == len - 1);
            end
        end
        idle(4);

        // Reset in the middle of a frame.
        frame(100, 32'd256, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 32'd256, 1'b0);
        tb_rst = 1'b1;
        #1;
        check("rst_mid_rom_addr", 64'(rom_addr), 64'd0);
        model_reset();
        @(posedge clk_tb);
        #1;
        tb_rst = 1'b0;
        idle(4);
        frame(512, 32'd256, 1'b0);
        idle(4);

        // Counter overflow: 513 bins without last, then a last bin.
        for (int i = 0; i < 513; i++) step(1'b1, 32'd100, 1'b0);
        step(1'b1, 32'd100, 1'b1);
        idle(6);
        check("bin_ovf_sticky", 64'(bin_ovf), 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
